// File: rtl/load_extend_sequencer.sv
// load_extend_sequencer
// Multi-cycle sub-word load controller. It accepts one load request, issues a
// single word-aligned read to data memory, waits for the response, then picks
// the addressed byte or halfword lane and sign- or zero-extends it to 32 bits.
// The result goes to writeback over a valid/ready handshake. Misaligned
// requests, the reserved size encoding and memory timeouts return an error
// result with zero data.
module load_extend_sequencer #(
  parameter int AW      = 32,  // byte address width
  parameter int TIMEOUT = 255  // WAIT cycles before abort, 0 disables
) (
  input  logic          clk,
  input  logic          rst,

  // Load request from the pipeline
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_signed,

  // Data memory read port
  output logic          mem_rd_valid,
  input  logic          mem_rd_ready,
  output logic [AW-1:0] mem_rd_addr,
  input  logic          mem_rsp_valid,
  input  logic [31:0]   mem_rsp_data,

  // Result to writeback
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_data,
  output logic          res_err
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Counter is wide enough to hold TIMEOUT itself, so the terminal compare
  // never sees a wrapped value.
  localparam int            CW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam bit            TIMEOUT_EN = (TIMEOUT != 0);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // A request is illegal when its size is reserved or its address is not
  // naturally aligned for that size.
  function automatic logic is_illegal(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    unique case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Select the addressed lane of a little-endian word and extend it.
  // Word loads pass through untouched; the signed flag only matters for
  // byte and halfword loads.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  addr_lo,
                                              input logic        sgn);
    logic [7:0]  byte_f;
    logic [15:0] half_f;
    logic [31:0] result;
    unique case (addr_lo)
      2'd0:    byte_f = word[7:0];
      2'd1:    byte_f = word[15:8];
      2'd2:    byte_f = word[23:16];
      default: byte_f = word[31:24];
    endcase
    half_f = addr_lo[1] ? word[31:16] : word[15:0];
    unique case (size)
      SIZE_BYTE: result = {{24{sgn & byte_f[7]}}, byte_f};
      SIZE_HALF: result = {{16{sgn & half_f[15]}}, half_f};
      default:   result = word;
    endcase
    return result;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t        state_q;
  logic          req_ready_q;
  logic          mem_rd_valid_q;
  logic [AW-1:0] mem_rd_addr_q;
  logic          res_valid_q;
  logic [31:0]   res_data_q;
  logic          res_err_q;
  logic [CW-1:0] cnt_q;

  // Captured request attributes needed once the response arrives
  logic [1:0]    size_q;
  logic [1:0]    addr_lo_q;
  logic          signed_q;

  // Next-value helpers derived from current state and inputs
  logic [CW-1:0] cnt_d;
  logic [31:0]   ext_d;
  logic [AW-1:0] word_addr_d;
  logic          illegal_d;

  // Combinational helpers: counter increment, lane extraction, request checks.
  // NOTE: every output of an always_comb gets a value on every path, which is
  // what keeps synthesis from inferring a latch.
  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    ext_d       = extend_load(mem_rsp_data, size_q, addr_lo_q, signed_q);
    word_addr_d = {req_addr[AW-1:2], 2'b00};
    illegal_d   = is_illegal(req_size, req_addr[1:0]);
  end

  // Sequencer FSM with registered handshake and result outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge regardless of
  // statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      req_ready_q    <= 1'b0;
      mem_rd_valid_q <= 1'b0;
      mem_rd_addr_q  <= '0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_err_q      <= 1'b0;
      cnt_q          <= '0;
      size_q         <= SIZE_BYTE;
      addr_lo_q      <= 2'b00;
      signed_q       <= 1'b0;
    end else begin
      unique case (state_q)
        // Ready to accept; illegal requests short-circuit straight to DONE
        // without touching memory.
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            size_q      <= req_size;
            addr_lo_q   <= req_addr[1:0];
            signed_q    <= req_signed;
            if (illegal_d) begin
              res_valid_q <= 1'b1;
              res_err_q   <= 1'b1;
              res_data_q  <= '0;
              state_q     <= S_DONE;
            end else begin
              mem_rd_valid_q <= 1'b1;
              mem_rd_addr_q  <= word_addr_d;
              state_q        <= S_REQ;
            end
          end
        end

        // Read request held stable until memory takes it.
        S_REQ: begin
          if (mem_rd_ready) begin
            mem_rd_valid_q <= 1'b0;
            cnt_q          <= '0;
            state_q        <= S_WAIT;
          end
        end

        // Waiting for data; a response in the timeout cycle still wins.
        S_WAIT: begin
          if (mem_rsp_valid) begin
            res_valid_q <= 1'b1;
            res_data_q  <= ext_d;
            res_err_q   <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
            if (TIMEOUT_EN && (cnt_d == TIMEOUT_C)) begin
              res_valid_q <= 1'b1;
              res_data_q  <= '0;
              res_err_q   <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end

        // Result held until writeback takes it. req_ready stays low during
        // the handshake cycle, so a new request is only seen back in IDLE.
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // req_ready is forced low combinationally while rst is asserted; every
  // other output comes straight from a register.
  assign req_ready    = req_ready_q & ~rst;
  assign mem_rd_valid = mem_rd_valid_q;
  assign mem_rd_addr  = mem_rd_addr_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_err      = res_err_q;

  // ---------------------------------------------------------------------------
  // Interface properties
  // ---------------------------------------------------------------------------
  // Memory reads are always word aligned.
  a_rd_addr_aligned : assert property (
    @(posedge clk) disable iff (rst) mem_rd_addr[1:0] == 2'b00);

  // Only one side of the transaction is active at a time.
  a_one_phase : assert property (
    @(posedge clk) disable iff (rst)
      !(mem_rd_valid && res_valid) && !(req_ready && (mem_rd_valid || res_valid)));

  // A stalled read request keeps its address.
  a_rd_stable : assert property (
    @(posedge clk) disable iff (rst)
      (mem_rd_valid && !mem_rd_ready) |=> (mem_rd_valid && $stable(mem_rd_addr)));

  // A stalled result keeps its payload.
  a_res_stable : assert property (
    @(posedge clk) disable iff (rst)
      (res_valid && !res_ready) |=> (res_valid && $stable(res_data) && $stable(res_err)));

endmodule

// File: tb/tb_load_extend_sequencer.sv
// tb_load_extend_sequencer
// Table-driven bench for load_extend_sequencer. Each vector describes one
// load plus the memory/writeback stall pattern around it; expected results
// are queued at accept time and compared when the result handshake happens.
// Hand-written sequences cover power-on reset, reset in WAIT and responses
// arriving outside WAIT.
module tb_load_extend_sequencer;

  localparam int          AW       = 32;
  localparam int          TO       = 4;
  localparam logic [31:0] MEM_WORD = 32'h80F1_7F22;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_size;
  logic          req_signed;
  logic          mem_rd_valid;
  logic          mem_rd_ready;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic          res_err;

  load_extend_sequencer #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_ready  (mem_rd_ready),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_err       (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One load scenario: request, expected result, and environment behaviour.
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] exp_data;
    logic        exp_err;
    bit          illegal;    // rejected at accept, no memory access expected
    int          rd_stall;   // cycles mem_rd_ready is held low
    int          res_stall;  // cycles res_ready is held low
    bit          rsp_en;     // memory returns data after accepting
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] size,
                              input logic sgn, input logic [31:0] exp_data,
                              input logic exp_err, input bit illegal,
                              input int rd_stall, input int res_stall,
                              input bit rsp_en);
    vec_t v;
    v.addr = addr; v.size = size; v.sgn = sgn;
    v.exp_data = exp_data; v.exp_err = exp_err; v.illegal = illegal;
    v.rd_stall = rd_stall; v.res_stall = res_stall; v.rsp_en = rsp_en;
    return v;
  endfunction

  // Drive one load through the DUT, acting as memory and writeback.
  // Inputs change and outputs are sampled on the falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    int          cyc;
    int          exp_lat;
    int          rd_left;
    int          res_left;
    bit          first_res;
    bit          saw_rd;
    bit          rsp_pending;
    bit          done;
    logic [31:0] hold_addr;
    logic [31:0] hold_data;
    logic        hold_err;
    exp_t        e;

    // accept = cycle 0; legal loads finish 3 cycles later plus read stalls,
    // timeouts after TO WAIT cycles, illegal requests on the next cycle.
    exp_lat = v.illegal ? 1 : (v.rsp_en ? 3 + v.rd_stall : 2 + v.rd_stall + TO);

    @(negedge clk);
    check({tag, " req_ready before accept"}, req_ready, 1'b1);
    req_valid  = 1'b1;
    req_addr   = v.addr;
    req_size   = v.size;
    req_signed = v.sgn;
    @(posedge clk);
    sb_q.push_back('{data: v.exp_data, err: v.exp_err});

    cyc = 0; done = 1'b0; first_res = 1'b0; saw_rd = 1'b0; rsp_pending = 1'b0;
    rd_left = v.rd_stall; res_left = v.res_stall;
    hold_addr = '0; hold_data = '0; hold_err = 1'b0;

    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      req_valid     = 1'b0;
      mem_rsp_valid = 1'b0;
      if (rsp_pending) begin
        mem_rsp_valid = 1'b1;
        rsp_pending   = 1'b0;
      end
      if (mem_rd_valid) begin
        if (!saw_rd) begin
          saw_rd    = 1'b1;
          hold_addr = mem_rd_addr;
          check({tag, " mem_rd_addr"}, mem_rd_addr, v.addr & 32'hFFFF_FFFC);
        end else begin
          check({tag, " mem_rd_addr stable"}, mem_rd_addr, hold_addr);
        end
        if (rd_left > 0) begin
          mem_rd_ready = 1'b0;
          rd_left--;
        end else begin
          mem_rd_ready = 1'b1;
          rsp_pending  = v.rsp_en;
        end
      end else begin
        mem_rd_ready = 1'b0;
      end
      if (res_valid) begin
        if (!first_res) begin
          first_res = 1'b1;
          hold_data = res_data;
          hold_err  = res_err;
          check({tag, " latency"}, cyc, exp_lat);
        end else begin
          check({tag, " res_data stable"}, res_data, hold_data);
          check({tag, " res_err stable"}, res_err, hold_err);
        end
        // a response arriving after the timeout must not change the result
        if (!v.rsp_en) mem_rsp_valid = 1'b1;
        if (res_left > 0) begin
          res_ready = 1'b0;
          res_left--;
          check({tag, " req_ready low in DONE"}, req_ready, 1'b0);
          req_valid  = 1'b1;
          req_addr   = 32'h0000_0200;
          req_size   = 2'b00;
          req_signed = 1'b0;
        end else begin
          res_ready = 1'b1;
          req_valid = (v.res_stall > 0);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, " res_data"}, res_data, e.data);
            check({tag, " res_err"}, res_err, e.err);
          end else begin
            check({tag, " scoreboard entry"}, sb_q.size(), 1);
          end
          done = 1'b1;
        end
      end
    end

    check({tag, " result seen"}, done, 1'b1);
    check({tag, " memory accessed"}, saw_rd, !v.illegal);

    @(posedge clk);
    @(negedge clk);
    res_ready     = 1'b0;
    req_valid     = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rd_ready  = 1'b0;
    check({tag, " idle req_ready"}, req_ready, 1'b1);
    check({tag, " idle res_valid"}, res_valid, 1'b0);
    check({tag, " idle mem_rd_valid"}, mem_rd_valid, 1'b0);
  endtask

  vec_t vecs[18];

  initial begin
    //             addr          size   sgn   exp_data       err   ill  rds rss rsp
    vecs[0]  = mk(32'h0000_0103, 2'b00, 1'b1, 32'hFFFF_FF80, 1'b0, 0,   0,  0,  1); // LB
    vecs[1]  = mk(32'h0000_0103, 2'b00, 1'b0, 32'h0000_0080, 1'b0, 0,   0,  0,  1); // LBU
    vecs[2]  = mk(32'h0000_0101, 2'b00, 1'b1, 32'h0000_007F, 1'b0, 0,   0,  0,  1); // LB
    vecs[3]  = mk(32'h0000_0102, 2'b01, 1'b1, 32'hFFFF_80F1, 1'b0, 0,   0,  0,  1); // LH
    vecs[4]  = mk(32'h0000_0102, 2'b01, 1'b0, 32'h0000_80F1, 1'b0, 0,   0,  0,  1); // LHU
    vecs[5]  = mk(32'h0000_0100, 2'b01, 1'b1, 32'h0000_7F22, 1'b0, 0,   0,  0,  1); // LH
    vecs[6]  = mk(32'h0000_0100, 2'b10, 1'b1, 32'h80F1_7F22, 1'b0, 0,   0,  0,  1); // LW
    vecs[7]  = mk(32'h0000_0102, 2'b00, 1'b0, 32'h0000_00F1, 1'b0, 0,   0,  0,  1); // LBU
    vecs[8]  = mk(32'h0000_0102, 2'b00, 1'b1, 32'hFFFF_FFF1, 1'b0, 0,   0,  0,  1); // LB
    vecs[9]  = mk(32'h0000_0104, 2'b10, 1'b0, 32'h80F1_7F22, 1'b0, 0,   0,  0,  1); // LW
    vecs[10] = mk(32'h0000_0101, 2'b10, 1'b1, 32'h0000_0000, 1'b1, 1,   0,  0,  1); // LW misaligned
    vecs[11] = mk(32'h0000_0103, 2'b01, 1'b1, 32'h0000_0000, 1'b1, 1,   0,  0,  1); // LH misaligned
    vecs[12] = mk(32'h0000_0100, 2'b11, 1'b0, 32'h0000_0000, 1'b1, 1,   0,  0,  1); // reserved size
    vecs[13] = mk(32'h0000_0102, 2'b01, 1'b1, 32'hFFFF_80F1, 1'b0, 0,   3,  0,  1); // read stall
    vecs[14] = mk(32'h0000_0101, 2'b00, 1'b0, 32'h0000_007F, 1'b0, 0,   0,  5,  1); // result stall
    vecs[15] = mk(32'h0000_0100, 2'b10, 1'b1, 32'h0000_0000, 1'b1, 0,   0,  2,  0); // timeout
    vecs[16] = mk(32'h0000_0100, 2'b01, 1'b0, 32'h0000_7F22, 1'b0, 0,   1,  1,  1); // both stalls
    vecs[17] = mk(32'h0000_0103, 2'b01, 1'b0, 32'h0000_0000, 1'b1, 1,   0,  3,  1); // illegal + stall

    rst           = 1'b1;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_size      = 2'b00;
    req_signed    = 1'b0;
    mem_rd_ready  = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = MEM_WORD;
    res_ready     = 1'b0;

    // Power-on reset: everything low and zero.
    #2;
    check("reset req_ready", req_ready, 1'b0);
    check("reset mem_rd_valid", mem_rd_valid, 1'b0);
    check("reset res_valid", res_valid, 1'b0);
    check("reset mem_rd_addr", mem_rd_addr, 32'h0);
    check("reset res_data", res_data, 32'h0);
    check("reset res_err", res_err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("req_ready after first edge", req_ready, 1'b1);

    // Table-driven loads.
    for (int i = 0; i < 18; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // A response pulse while idle must not create a result.
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("idle rsp ignored res_valid", res_valid, 1'b0);
    check("idle rsp ignored req_ready", req_ready, 1'b1);

    // Reset while in WAIT abandons the load.
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0104;
    req_size   = 2'b10;
    req_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst mem_rd_valid", mem_rd_valid, 1'b1);
    mem_rd_ready = 1'b1;
    @(negedge clk);
    mem_rd_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst req_ready", req_ready, 1'b0);
    check("midrst mem_rd_valid 0", mem_rd_valid, 1'b0);
    check("midrst res_valid", res_valid, 1'b0);
    check("midrst mem_rd_addr", mem_rd_addr, 32'h0);
    check("midrst res_data", res_data, 32'h0);
    check("midrst res_err", res_err, 1'b0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post-reset res_valid c%0d", c), res_valid, 1'b0);
      check($sformatf("post-reset mem_rd_valid c%0d", c), mem_rd_valid, 1'b0);
      check($sformatf("post-reset req_ready c%0d", c), req_ready, 1'b1);
    end
    run_vec(mk(32'h0000_0100, 2'b00, 1'b1, 32'h0000_0022, 1'b0, 0, 0, 0, 1), "after reset LB");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/load_extend_sequencer.md
Name: load_extend_sequencer

Overview:
- Multi-cycle controller for sub-word loads.
- Accepts a load request from the pipeline, issues one word-aligned read to data memory, and waits for the response.
- Selects the addressed byte or halfword lane, then sign- or zero-extends it to 32 bits.
- Returns the result to the writeback stage over a valid/ready handshake. Misalignment and memory timeouts are reported as errors.

Parameters:
- AW, 32, address width.
- TIMEOUT, 255, maximum WAIT cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  sequencer can accept a request.
- req_addr  in  AW  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  1 = sign-extend, 0 = zero-extend.
- mem_rd_valid  out  1  memory read request.
- mem_rd_ready  in  1  memory accepts the read.
- mem_rd_addr  out  AW  word address; bits [1:0] are always 0.
- mem_rsp_valid  in  1  read data valid, single-cycle pulse.
- mem_rsp_data  in  32  read word, little-endian lanes.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  32  extended load value.
- res_err  out  1  misaligned, reserved size, or timeout.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Exactly one transaction is in flight.
- Reset (async, any state):
  - State goes to IDLE.
  - req_ready, mem_rd_valid and res_valid are 0 while rst is high.
  - mem_rd_addr, res_data, res_err and the WAIT counter are 0.
  - req_ready is 1 from the first clock edge after rst deasserts.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: capture addr, size and signed.
  - Illegal request (size 11, half with addr[0]=1, or word with addr[1:0]!=0): go to DONE with res_err=1, res_data=0. No memory access is made.
  - Legal request: go to REQ.
- REQ:
  - mem_rd_valid = 1 and mem_rd_addr = {addr[AW-1:2], 2'b00}; both are held stable until mem_rd_ready.
  - On mem_rd_ready: go to WAIT and clear the counter.
- WAIT:
  - On mem_rsp_valid: load res_data with the extended value, set res_err=0, go to DONE.
  - Otherwise the counter increments each cycle.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT: go to DONE with res_err=1, res_data=0.
  - A response arriving in the same cycle as the timeout wins (no error).
- DONE:
  - res_valid = 1; res_data and res_err are held stable until res_ready.
  - On res_ready: go to IDLE. req_ready is 0 in that cycle, so there is no same-cycle re-accept.
- Lane select and extension:
  - Byte: lane = addr[1:0], field = data[8*lane+7 : 8*lane].
  - Half: field = data[16*addr[1]+15 : 16*addr[1]].
  - Signed: upper bits replicate the field MSB. Unsigned: upper bits are 0.
  - Word: data passes through unchanged; req_signed is ignored.
- mem_rsp_valid outside WAIT is ignored.
- Minimum latency: accept at cycle 0, mem_rd_valid at cycle 1, response at cycle 2, res_valid at cycle 3.
- Reset mid-operation abandons the transaction. The memory is reset together with this block, so no stale response is possible.
- All outputs are driven from registered state; there is no combinational path from inputs to outputs except req_ready's dependence on rst.

Test Plan:
In all scenarios mem_rsp_data = 0x80F17F22 and the memory responds one cycle after accepting, unless stated otherwise.
- Byte loads:
  - LB addr 0x103 signed -> res_data 0xFFFFFF80, res_err 0.
  - LBU addr 0x103 -> 0x00000080.
  - LB addr 0x101 signed -> 0x0000007F.
  - mem_rd_addr is 0x100 in every case.
- Halfword and word loads:
  - LH addr 0x102 signed -> 0xFFFF80F1.
  - LHU addr 0x102 -> 0x000080F1.
  - LH addr 0x100 signed -> 0x00007F22.
  - LW addr 0x100 signed -> 0x80F17F22.
  - Each result appears exactly 3 cycles after accept.
- Illegal requests:
  - LW addr 0x101 -> res_err 1, res_data 0, mem_rd_valid never asserted.
  - LH addr 0x103 -> same response.
  - size 11 -> same response.
- Backpressure:
  - mem_rd_ready low for 3 cycles -> mem_rd_valid and mem_rd_addr stable throughout.
  - res_ready low for 5 cycles -> res_valid, res_data and res_err stable, req_ready 0, and a second req_valid is not accepted.
- Timeout (TIMEOUT=4, no response):
  - res_err 1 after exactly 4 WAIT cycles.
  - A late mem_rsp_valid is then ignored.
- Reset mid-operation:
  - rst pulsed while in WAIT -> all outputs 0 immediately.
  - After release: IDLE with req_ready 1, no res_valid pulse.
  - The next LB addr 0x100 completes normally with 0x00000022.
